// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM and the register bank between the
// SPI loader and the core data port (round-robin, optional bus lock).
module dmem_arbiter #(
    parameter int RAM_AW  = 14,
    parameter int REG_AW  = 4,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       spi_haddr,
    input  logic [1:0]        spi_htrans,
    input  logic              spi_hwrite,
    input  logic [2:0]        spi_hsize,
    input  logic [31:0]       spi_hwdata,
    input  logic              spi_hmastlock,
    output logic              spi_hready,
    output logic              spi_hresp,
    output logic [31:0]       spi_hrdata,
    input  logic [31:0]       dmem_haddr,
    input  logic [1:0]        dmem_htrans,
    input  logic              dmem_hwrite,
    input  logic [2:0]        dmem_hsize,
    input  logic [31:0]       dmem_hwdata,
    input  logic              dmem_hmastlock,
    output logic              dmem_hready,
    output logic              dmem_hresp,
    output logic [31:0]       dmem_hrdata,
    output logic [RAM_AW-1:0] data_addr,
    output logic [31:0]       data_write,
    output logic              data_rwn,
    input  logic [31:0]       data_read,
    output logic [REG_AW-1:0] reg_addr,
    output logic [31:0]       reg_write,
    output logic [3:0]        reg_wben,
    output logic              reg_rwn,
    input  logic [31:0]       reg_read,
    output logic              grant_core
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t              state_q;
    logic                grant_core_q;
    logic                lock_q;
    logic                lock_req_q;
    logic                write_q;
    logic                sel_reg_q;
    logic                err_q;
    logic                spi_hready_q;
    logic                spi_hresp_q;
    logic [31:0]         spi_hrdata_q;
    logic                dmem_hready_q;
    logic                dmem_hresp_q;
    logic [31:0]         dmem_hrdata_q;
    logic [RAM_AW-1:0]   data_addr_q;
    logic [31:0]         data_write_q;
    logic                data_rwn_q;
    logic [REG_AW-1:0]   reg_addr_q;
    logic [31:0]         reg_write_q;
    logic [3:0]          reg_wben_q;
    logic                reg_rwn_q;

    logic                req_spi;
    logic                req_core;
    logic                any_req;
    logic                lock_hold;
    logic                grant_core_d;
    logic [31:0]         w_addr;
    logic                w_write;
    logic [2:0]          w_size;
    logic [31:0]         w_wdata;
    logic                w_lock;
    logic                w_reg;
    logic                w_err;
    logic [3:0]          w_wben;
    logic [31:0]         rdata_sel;
    logic                rd_ok;
    logic                unused_addr;

    // Arbitration, winner mux, address decode, error check and byte enables
    always_comb begin
        req_spi      = spi_htrans[1];
        req_core     = dmem_htrans[1];
        any_req      = req_spi | req_core;
        lock_hold    = lock_q && (grant_core_q ? req_core : req_spi);
        grant_core_d = grant_core_q;
        if (lock_hold)
            grant_core_d = grant_core_q;
        else if (req_spi && req_core)
            grant_core_d = !grant_core_q;
        else
            grant_core_d = req_core;

        w_addr  = grant_core_d ? dmem_haddr     : spi_haddr;
        w_write = grant_core_d ? dmem_hwrite    : spi_hwrite;
        w_size  = grant_core_d ? dmem_hsize     : spi_hsize;
        w_wdata = grant_core_d ? dmem_hwdata    : spi_hwdata;
        w_lock  = grant_core_d ? dmem_hmastlock : spi_hmastlock;

        w_reg = w_addr[15];
        w_err = (w_size > 3'd2) ||
                (!w_reg && w_write && (w_size != 3'd2));

        w_wben = 4'b1111;
        case (w_size)
            3'd0:    w_wben = 4'b0001 << w_addr[1:0];
            3'd1:    w_wben = w_addr[1] ? 4'b1100 : 4'b0011;
            default: w_wben = 4'b1111;
        endcase

        rdata_sel = sel_reg_q ? reg_read : data_read;
        rd_ok     = !write_q && !err_q;
    end

    // Upper address bits are intentionally ignored by the decoder
    assign unused_addr = ^w_addr;

    // IDLE -> ISSUE -> DONE transfer sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_core_q  <= 1'b0;
            lock_q        <= 1'b0;
            lock_req_q    <= 1'b0;
            write_q       <= 1'b0;
            sel_reg_q     <= 1'b0;
            err_q         <= 1'b0;
            spi_hready_q  <= 1'b0;
            spi_hresp_q   <= 1'b0;
            spi_hrdata_q  <= '0;
            dmem_hready_q <= 1'b0;
            dmem_hresp_q  <= 1'b0;
            dmem_hrdata_q <= '0;
            data_addr_q   <= '0;
            data_write_q  <= '0;
            data_rwn_q    <= 1'b1;
            reg_addr_q    <= '0;
            reg_write_q   <= '0;
            reg_wben_q    <= '0;
            reg_rwn_q     <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_core_q <= grant_core_d;
                        lock_q       <= lock_hold;
                        lock_req_q   <= w_lock;
                        write_q      <= w_write;
                        sel_reg_q    <= w_reg;
                        err_q        <= w_err;
                        if (!w_err) begin
                            if (w_reg) begin
                                reg_addr_q <= w_addr[REG_AW-1:0];
                                reg_rwn_q  <= !w_write;
                                reg_wben_q <= w_write ? w_wben : 4'b0000;
                                if (w_write)
                                    reg_write_q <= w_wdata;
                            end else begin
                                data_addr_q <= w_addr[RAM_AW-1:0];
                                data_rwn_q  <= !w_write;
                                if (w_write)
                                    data_write_q <= w_wdata;
                            end
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    data_rwn_q <= 1'b1;
                    reg_rwn_q  <= 1'b1;
                    if (grant_core_q) begin
                        dmem_hready_q <= 1'b1;
                        dmem_hresp_q  <= err_q;
                    end else begin
                        spi_hready_q <= 1'b1;
                        spi_hresp_q  <= err_q;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    spi_hready_q  <= 1'b0;
                    spi_hresp_q   <= 1'b0;
                    dmem_hready_q <= 1'b0;
                    dmem_hresp_q  <= 1'b0;
                    if (rd_ok) begin
                        if (grant_core_q)
                            dmem_hrdata_q <= rdata_sel;
                        else
                            spi_hrdata_q <= rdata_sel;
                    end
                    lock_q  <= LOCK_EN && lock_req_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data is forwarded in the completion cycle, then held
    assign spi_hrdata  = (spi_hready_q && rd_ok) ? rdata_sel : spi_hrdata_q;
    assign dmem_hrdata = (dmem_hready_q && rd_ok) ? rdata_sel : dmem_hrdata_q;
    assign spi_hready  = spi_hready_q;
    assign spi_hresp   = spi_hresp_q;
    assign dmem_hready = dmem_hready_q;
    assign dmem_hresp  = dmem_hresp_q;
    assign grant_core  = grant_core_q;

    // A reset arriving during ISSUE must suppress the write strobe at once
    assign data_rwn   = data_rwn_q | reset;
    assign reg_rwn    = reg_rwn_q | reset;
    assign data_addr  = data_addr_q;
    assign data_write = data_write_q;
    assign reg_addr   = reg_addr_q;
    assign reg_write  = reg_write_q;
    assign reg_wben   = reg_wben_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios for the two-master data arbiter.
// Inputs change #1 after posedge, outputs are sampled on negedge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] spi_haddr, dmem_haddr;
    logic [1:0]  spi_htrans, dmem_htrans;
    logic        spi_hwrite, dmem_hwrite;
    logic [2:0]  spi_hsize, dmem_hsize;
    logic [31:0] spi_hwdata, dmem_hwdata;
    logic        spi_hmastlock, dmem_hmastlock;
    logic        spi_hready, dmem_hready;
    logic        spi_hresp, dmem_hresp;
    logic [31:0] spi_hrdata, dmem_hrdata;
    logic [13:0] data_addr;
    logic [31:0] data_write;
    logic        data_rwn;
    logic [31:0] data_read;
    logic [3:0]  reg_addr;
    logic [31:0] reg_write;
    logic [3:0]  reg_wben;
    logic        reg_rwn;
    logic [31:0] reg_read;
    logic        grant_core;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.RAM_AW(14), .REG_AW(4), .LOCK_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .spi_haddr(spi_haddr), .spi_htrans(spi_htrans),
        .spi_hwrite(spi_hwrite), .spi_hsize(spi_hsize),
        .spi_hwdata(spi_hwdata), .spi_hmastlock(spi_hmastlock),
        .spi_hready(spi_hready), .spi_hresp(spi_hresp),
        .spi_hrdata(spi_hrdata),
        .dmem_haddr(dmem_haddr), .dmem_htrans(dmem_htrans),
        .dmem_hwrite(dmem_hwrite), .dmem_hsize(dmem_hsize),
        .dmem_hwdata(dmem_hwdata), .dmem_hmastlock(dmem_hmastlock),
        .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp),
        .dmem_hrdata(dmem_hrdata),
        .data_addr(data_addr), .data_write(data_write),
        .data_rwn(data_rwn), .data_read(data_read),
        .reg_addr(reg_addr), .reg_write(reg_write),
        .reg_wben(reg_wben), .reg_rwn(reg_rwn), .reg_read(reg_read),
        .grant_core(grant_core)
    );

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({spi_hready, dmem_hready, spi_hresp, dmem_hresp} !== 4'b0) begin
            fails++;
            $display("FAIL reset_hs: got %b required 0000",
                     {spi_hready, dmem_hready, spi_hresp, dmem_hresp});
        end
        checks++;
        if (spi_hrdata !== 32'h0 || dmem_hrdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_hrdata: got %h/%h required 0/0", spi_hrdata, dmem_hrdata);
        end
        checks++;
        if (data_addr !== 14'h0 || data_write !== 32'h0 || reg_addr !== 4'h0 ||
            reg_write !== 32'h0 || reg_wben !== 4'h0) begin
            fails++;
            $display("FAIL reset_slave: got %h %h %h %h %h required zeros",
                     data_addr, data_write, reg_addr, reg_write, reg_wben);
        end
        checks++;
        if (data_rwn !== 1'b1 || reg_rwn !== 1'b1 || grant_core !== 1'b0) begin
            fails++;
            $display("FAIL reset_rwn_grant: got %b%b%b required 110",
                     data_rwn, reg_rwn, grant_core);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_spi_reg_write();
        @(posedge clk);
        #1;
        spi_haddr = 32'h0000_8005; spi_hwrite = 1'b1; spi_hsize = 3'd2;
        spi_hwdata = 32'h1234_5678; spi_htrans = 2'b10;
        @(negedge clk);
        checks++;
        if (spi_hready !== 1'b0) begin
            fails++; $display("FAIL wr_early_ready: got %b required 0", spi_hready);
        end
        @(negedge clk);
        checks++;
        if (reg_addr !== 4'h5 || reg_rwn !== 1'b0 || reg_wben !== 4'hF ||
            reg_write !== 32'h1234_5678) begin
            fails++;
            $display("FAIL wr_issue: got addr=%h rwn=%b wben=%b wd=%h required 5 0 1111 12345678",
                     reg_addr, reg_rwn, reg_wben, reg_write);
        end
        checks++;
        if (data_rwn !== 1'b1 || grant_core !== 1'b0) begin
            fails++;
            $display("FAIL wr_other: got data_rwn=%b grant=%b required 1 0", data_rwn, grant_core);
        end
        @(negedge clk);
        checks++;
        if (spi_hready !== 1'b1 || spi_hresp !== 1'b0 || reg_rwn !== 1'b1) begin
            fails++;
            $display("FAIL wr_done: got rdy=%b resp=%b rwn=%b required 1 0 1",
                     spi_hready, spi_hresp, reg_rwn);
        end
        spi_htrans = 2'b00; spi_hwrite = 1'b0;
        @(negedge clk);
        checks++;
        if (spi_hready !== 1'b0 || spi_hrdata !== 32'h0) begin
            fails++;
            $display("FAIL wr_after: got rdy=%b hrdata=%h required 0 0", spi_hready, spi_hrdata);
        end
    endtask

    task automatic test_core_read();
        @(posedge clk);
        #1;
        dmem_haddr = 32'h0000_0010; dmem_hwrite = 1'b0; dmem_hsize = 3'd2;
        dmem_htrans = 2'b10;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (data_addr !== 14'h10 || data_rwn !== 1'b1 || grant_core !== 1'b1) begin
            fails++;
            $display("FAIL rd_issue: got addr=%h rwn=%b grant=%b required 10 1 1",
                     data_addr, data_rwn, grant_core);
        end
        @(negedge clk);
        checks++;
        if (dmem_hready !== 1'b1 || dmem_hresp !== 1'b0 || dmem_hrdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL rd_done: got rdy=%b resp=%b data=%h required 1 0 deadbeef",
                     dmem_hready, dmem_hresp, dmem_hrdata);
        end
        checks++;
        if (spi_hready !== 1'b0 || spi_hrdata !== 32'h0) begin
            fails++;
            $display("FAIL rd_nonowner: got rdy=%b data=%h required 0 0", spi_hready, spi_hrdata);
        end
        dmem_htrans = 2'b00;
        @(negedge clk);
        data_read = 32'h0;
        #1;
        checks++;
        if (dmem_hready !== 1'b0 || dmem_hrdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL rd_hold: got rdy=%b data=%h required 0 deadbeef", dmem_hready, dmem_hrdata);
        end
        data_read = 32'hDEAD_BEEF;
    endtask

    task automatic test_round_robin();
        int spi_at, core_at, spi_n, core_n;
        spi_haddr = 32'h0000_8003; spi_hwrite = 1'b0; spi_hsize = 3'd2;
        dmem_haddr = 32'h0000_0044; dmem_hwrite = 1'b0; dmem_hsize = 3'd2;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                spi_at = -1;
                @(posedge clk);
                #1 spi_htrans = 2'b10;
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    if (spi_hready === 1'b1 && spi_at < 0) begin
                        spi_at = c; spi_htrans = 2'b00;
                    end
                end
                checks++;
                if (spi_at != 2) begin
                    fails++; $display("FAIL rr_spi_only: got cycle %0d required 2", spi_at);
                end
                reg_read = 32'h0F0F_0F0F;
                data_read = 32'h7654_3210;
            end
            spi_at = -1; core_at = -1; spi_n = 0; core_n = 0;
            @(posedge clk);
            #1;
            spi_htrans = 2'b10; dmem_htrans = 2'b10;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (r == 0 && c == 1) begin
                    checks++;
                    if (reg_wben !== 4'b0000 || reg_addr !== 4'h3) begin
                        fails++;
                        $display("FAIL rr_rd_wben: got wben=%b addr=%h required 0000 3",
                                 reg_wben, reg_addr);
                    end
                end
                if (spi_hready === 1'b1) begin
                    spi_n++; spi_at = c; spi_htrans = 2'b00;
                end
                if (dmem_hready === 1'b1) begin
                    core_n++; core_at = c; dmem_htrans = 2'b00;
                end
            end
            checks++;
            if (spi_at != ((r == 0) ? 2 : 5) || core_at != ((r == 0) ? 5 : 2)) begin
                fails++;
                $display("FAIL rr_order_%0d: got spi@%0d core@%0d required spi@%0d core@%0d",
                         r, spi_at, core_at, (r == 0) ? 2 : 5, (r == 0) ? 5 : 2);
            end
            checks++;
            if (spi_n != 1 || core_n != 1) begin
                fails++;
                $display("FAIL rr_pulses_%0d: got %0d/%0d required 1/1", r, spi_n, core_n);
            end
            checks++;
            if (spi_hrdata !== ((r == 0) ? 32'hCAFE_F00D : 32'h0F0F_0F0F) ||
                dmem_hrdata !== ((r == 0) ? 32'hDEAD_BEEF : 32'h7654_3210)) begin
                fails++;
                $display("FAIL rr_data_%0d: got %h/%h", r, spi_hrdata, dmem_hrdata);
            end
        end
    endtask

    task automatic test_lock();
        int core_t[3];
        int core_n, spi_at;
        core_n = 0; spi_at = -1;
        for (int i = 0; i < 3; i++) core_t[i] = -1;
        dmem_haddr = 32'h0000_0100; dmem_hwrite = 1'b1; dmem_hsize = 3'd2;
        dmem_hwdata = 32'hA5A5_A5A5; dmem_hmastlock = 1'b1;
        spi_haddr = 32'h0000_8001; spi_hwrite = 1'b0; spi_hsize = 3'd2;
        @(posedge clk);
        #1;
        spi_htrans = 2'b10; dmem_htrans = 2'b10;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (dmem_hready === 1'b1) begin
                if (core_n < 3) core_t[core_n] = c;
                core_n++;
                if (core_n == 3) begin
                    dmem_htrans = 2'b00; dmem_hmastlock = 1'b0;
                end
            end
            if (spi_hready === 1'b1 && spi_at < 0) begin
                spi_at = c; spi_htrans = 2'b00;
            end
        end
        checks++;
        if (core_n != 3 || core_t[0] != 2 || core_t[1] != 5 || core_t[2] != 8) begin
            fails++;
            $display("FAIL lock_core: got n=%0d at %0d,%0d,%0d required 3 at 2,5,8",
                     core_n, core_t[0], core_t[1], core_t[2]);
        end
        checks++;
        if (spi_at != 11) begin
            fails++; $display("FAIL lock_spi: got cycle %0d required 11", spi_at);
        end
        checks++;
        if (data_write !== 32'hA5A5_A5A5 || dmem_hrdata !== 32'h7654_3210) begin
            fails++;
            $display("FAIL lock_data: got wd=%h hrdata=%h required a5a5a5a5 76543210",
                     data_write, dmem_hrdata);
        end
    endtask

    task automatic test_errors();
        // byte write to data RAM
        @(posedge clk);
        #1;
        dmem_haddr = 32'h0000_0020; dmem_hwrite = 1'b1; dmem_hsize = 3'd0;
        dmem_hwdata = 32'hAAAA_AAAA; dmem_htrans = 2'b10;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (data_rwn !== 1'b1) begin
            fails++; $display("FAIL err_ram_rwn: got %b required 1", data_rwn);
        end
        @(negedge clk);
        checks++;
        if (dmem_hready !== 1'b1 || dmem_hresp !== 1'b1 || dmem_hrdata !== 32'h7654_3210) begin
            fails++;
            $display("FAIL err_ram_done: got rdy=%b resp=%b data=%h required 1 1 76543210",
                     dmem_hready, dmem_hresp, dmem_hrdata);
        end
        dmem_htrans = 2'b00;
        @(negedge clk);
        checks++;
        if (dmem_hresp !== 1'b0 || dmem_hready !== 1'b0) begin
            fails++;
            $display("FAIL err_ram_after: got resp=%b rdy=%b required 0 0", dmem_hresp, dmem_hready);
        end
        // illegal size read from the register bank
        reg_read = 32'h5555_5555;
        @(posedge clk);
        #1;
        spi_haddr = 32'h0000_8001; spi_hwrite = 1'b0; spi_hsize = 3'd3;
        spi_htrans = 2'b10;
        repeat (3) @(negedge clk);
        checks++;
        if (spi_hready !== 1'b1 || spi_hresp !== 1'b1 || spi_hrdata !== 32'h0F0F_0F0F) begin
            fails++;
            $display("FAIL err_size: got rdy=%b resp=%b data=%h required 1 1 0f0f0f0f",
                     spi_hready, spi_hresp, spi_hrdata);
        end
        spi_htrans = 2'b00;
        // byte write to register 2
        @(posedge clk);
        #1;
        dmem_haddr = 32'h0000_8002; dmem_hwrite = 1'b1; dmem_hsize = 3'd0;
        dmem_hwdata = 32'h00AB_0000; dmem_htrans = 2'b10;
        repeat (2) @(negedge clk);
        checks++;
        if (reg_wben !== 4'b0100 || reg_rwn !== 1'b0 || reg_addr !== 4'h2 ||
            reg_write !== 32'h00AB_0000) begin
            fails++;
            $display("FAIL reg_byte: got wben=%b rwn=%b addr=%h wd=%h required 0100 0 2 00ab0000",
                     reg_wben, reg_rwn, reg_addr, reg_write);
        end
        @(negedge clk);
        checks++;
        if (dmem_hready !== 1'b1 || dmem_hresp !== 1'b0) begin
            fails++;
            $display("FAIL reg_byte_done: got rdy=%b resp=%b required 1 0", dmem_hready, dmem_hresp);
        end
        dmem_htrans = 2'b00;
        // halfword write to register 6
        @(posedge clk);
        #1;
        spi_haddr = 32'h0000_8006; spi_hwrite = 1'b1; spi_hsize = 3'd1;
        spi_hwdata = 32'hBEEF_0000; spi_htrans = 2'b10;
        repeat (2) @(negedge clk);
        checks++;
        if (reg_wben !== 4'b1100 || reg_addr !== 4'h6 || reg_write !== 32'hBEEF_0000) begin
            fails++;
            $display("FAIL reg_half: got wben=%b addr=%h wd=%h required 1100 6 beef0000",
                     reg_wben, reg_addr, reg_write);
        end
        @(negedge clk);
        checks++;
        if (spi_hready !== 1'b1 || spi_hresp !== 1'b0) begin
            fails++;
            $display("FAIL reg_half_done: got rdy=%b resp=%b required 1 0", spi_hready, spi_hresp);
        end
        spi_htrans = 2'b00; spi_hwrite = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n_rdy;
        @(posedge clk);
        #1;
        dmem_haddr = 32'h0000_8007; dmem_hwrite = 1'b1; dmem_hsize = 3'd2;
        dmem_hwdata = 32'h0000_0099; dmem_htrans = 2'b10;
        @(posedge clk);
        #1;
        reset = 1'b1; dmem_htrans = 2'b00;
        #1;
        checks++;
        if (reg_rwn !== 1'b1 || data_rwn !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_strobe: got reg_rwn=%b data_rwn=%b required 1 1", reg_rwn, data_rwn);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({spi_hready, dmem_hready, spi_hresp, dmem_hresp, grant_core} !== 5'b0 ||
            spi_hrdata !== 32'h0 || dmem_hrdata !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_master: got %b %h %h required zeros",
                     {spi_hready, dmem_hready, spi_hresp, dmem_hresp, grant_core},
                     spi_hrdata, dmem_hrdata);
        end
        checks++;
        if (data_addr !== 14'h0 || data_write !== 32'h0 || reg_addr !== 4'h0 ||
            reg_write !== 32'h0 || reg_wben !== 4'h0 || data_rwn !== 1'b1 || reg_rwn !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_slave: got %h %h %h %h %b %b %b",
                     data_addr, data_write, reg_addr, reg_write, reg_wben, data_rwn, reg_rwn);
        end
        n_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (spi_hready === 1'b1 || dmem_hready === 1'b1) n_rdy++;
        end
        checks++;
        if (n_rdy != 0) begin
            fails++; $display("FAIL rst_mid_noready: got %0d pulses required 0", n_rdy);
        end
        data_read = 32'h1357_2468;
        @(posedge clk);
        #1;
        dmem_haddr = 32'h0000_0008; dmem_hwrite = 1'b0; dmem_hsize = 3'd2;
        dmem_htrans = 2'b10;
        repeat (3) @(negedge clk);
        checks++;
        if (dmem_hready !== 1'b1 || dmem_hresp !== 1'b0 || dmem_hrdata !== 32'h1357_2468) begin
            fails++;
            $display("FAIL rst_mid_fresh: got rdy=%b resp=%b data=%h required 1 0 13572468",
                     dmem_hready, dmem_hresp, dmem_hrdata);
        end
        dmem_htrans = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        spi_haddr = '0; spi_htrans = '0; spi_hwrite = 1'b0; spi_hsize = 3'd2;
        spi_hwdata = '0; spi_hmastlock = 1'b0;
        dmem_haddr = '0; dmem_htrans = '0; dmem_hwrite = 1'b0; dmem_hsize = 3'd2;
        dmem_hwdata = '0; dmem_hmastlock = 1'b0;
        data_read = 32'hDEAD_BEEF;
        reg_read = 32'hCAFE_F00D;
        test_reset();
        test_spi_reg_write();
        test_core_read();
        test_round_robin();
        test_lock();
        test_errors();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
